// File: rtl/lab35_upcount.sv
// lab35_upcount: parameterised modulo-N up counter with enable, synchronous
// clear, clamped parallel load, wrap or saturate at MAX, and a combinational
// terminal-count carry for cascading into wider or decade counters.
module lab35_upcount #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = 15,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_out,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             sat_flag,
    output logic [7:0]       wrap_cnt
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic             at_max;
    logic [WIDTH-1:0] load_clamped;
    logic             do_inc;
    logic             do_wrap;
    logic             do_sat;

    assign at_max = (q_out == MAX_V);

    // Carry out is combinational so the next stage advances on the same edge
    // as this stage wraps; it stays asserted at MAX in saturate mode too.
    assign tc = at_max & en;

    // Decode the counting action for this cycle (lower-priority than clear/load).
    always_comb begin
        load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
        do_inc       = 1'b0;
        do_wrap      = 1'b0;
        do_sat       = 1'b0;
        if (en) begin
            if (!at_max) begin
                do_inc = 1'b1;
            end else if (SATURATE) begin
                do_sat = 1'b1;
            end else begin
                do_wrap = 1'b1;
            end
        end
    end

    // Count register: reset > clear > load > increment/wrap > hold.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q_out <= '0;
        end else if (load) begin
            q_out <= load_clamped;
        end else if (do_inc) begin
            q_out <= q_out + WIDTH'(1);
        end else if (do_wrap) begin
            q_out <= '0;
        end
    end

    // Status flags: wrap pulse lasts one cycle, saturation flag is sticky
    // until something moves the count off MAX.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wrap_pulse <= 1'b0;
            sat_flag   <= 1'b0;
        end else if (load) begin
            wrap_pulse <= 1'b0;
            sat_flag   <= SATURATE && (load_clamped == MAX_V);
        end else if (en) begin
            wrap_pulse <= do_wrap;
            sat_flag   <= do_sat;
        end else begin
            wrap_pulse <= 1'b0;
        end
    end

    // Wrap event counter, rolls over naturally at 255 -> 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wrap_cnt <= '0;
        end else if (!load && do_wrap) begin
            wrap_cnt <= wrap_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_lab35_upcount.sv
// Directed self-checking bench for lab35_upcount: free-running mod-16, cascaded
// decade pair, clamped load and priority, saturate mode, enable gating and
// reset squashing a pending wrap.
module tb_lab35_upcount;

    logic clk;
    logic reset;

    // A: WIDTH=4 MAX=15 wrap
    logic       en_a, clr_a, ld_a;
    logic [3:0] lv_a, q_a;
    logic       tc_a, wp_a, sf_a;
    logic [7:0] wc_a;

    // B: decade units, C: decade tens cascaded from B
    logic       en_b, clr_b, ld_b, ld_c;
    logic [3:0] lv_b, lv_c, q_b, q_c;
    logic       tc_b, wp_b, sf_b, tc_c, wp_c, sf_c;
    logic [7:0] wc_b, wc_c;

    // D: WIDTH=4 MAX=15 saturate
    logic       en_d, clr_d, ld_d;
    logic [3:0] lv_d, q_d;
    logic       tc_d, wp_d, sf_d;
    logic [7:0] wc_d;

    int n_assert = 0;
    int n_fail   = 0;

    lab35_upcount #(.WIDTH(4), .MAX(15), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset(reset), .en(en_a), .clear(clr_a), .load(ld_a),
        .load_val(lv_a), .q_out(q_a), .tc(tc_a), .wrap_pulse(wp_a),
        .sat_flag(sf_a), .wrap_cnt(wc_a)
    );

    lab35_upcount #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_units (
        .clk(clk), .reset(reset), .en(en_b), .clear(clr_b), .load(ld_b),
        .load_val(lv_b), .q_out(q_b), .tc(tc_b), .wrap_pulse(wp_b),
        .sat_flag(sf_b), .wrap_cnt(wc_b)
    );

    lab35_upcount #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_tens (
        .clk(clk), .reset(reset), .en(tc_b), .clear(clr_b), .load(ld_c),
        .load_val(lv_c), .q_out(q_c), .tc(tc_c), .wrap_pulse(wp_c),
        .sat_flag(sf_c), .wrap_cnt(wc_c)
    );

    lab35_upcount #(.WIDTH(4), .MAX(15), .SATURATE(1'b1)) u_d (
        .clk(clk), .reset(reset), .en(en_d), .clear(clr_d), .load(ld_d),
        .load_val(lv_d), .q_out(q_d), .tc(tc_d), .wrap_pulse(wp_d),
        .sat_flag(sf_d), .wrap_cnt(wc_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en_a = 1'b1; clr_a = 1'b0; ld_a = 1'b1; lv_a = 4'd9;
        en_b = 1'b1; clr_b = 1'b0; ld_b = 1'b1; lv_b = 4'd9;
        ld_c = 1'b0; lv_c = 4'd0;
        en_d = 1'b1; clr_d = 1'b0; ld_d = 1'b1; lv_d = 4'd9;

        // 1: reset dominates en and load for two edges
        step();
        step();
        chk("rst_q", q_a, 0);
        chk("rst_wc", wc_a, 0);
        chk("rst_wp", wp_a, 0);
        chk("rst_sf", sf_a, 0);
        chk("rst_qb", q_b, 0);
        chk("rst_qc", q_c, 0);
        chk("rst_qd", q_d, 0);
        chk("rst_sfd", sf_d, 0);

        reset = 1'b0;
        ld_a = 1'b0; ld_b = 1'b0; ld_d = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_d = 1'b0;
        #1;
        chk("tc_idle", tc_a, 0);

        // 2: free count mod 16, one wrap in 20 edges
        en_a = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("free_q", q_a, i % 16);
            chk("free_tc", tc_a, (i == 15) ? 1 : 0);
            chk("free_wp", wp_a, (i == 16) ? 1 : 0);
            chk("free_wc", wc_a, (i >= 16) ? 1 : 0);
        end
        en_a = 1'b0;

        // 3: cascaded decade counters count 00..99 then 00
        en_b = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            chk("dec_units", q_b, i % 10);
            chk("dec_tens", q_c, (i / 10) % 10);
            chk("dec_tc", tc_b, ((i % 10) == 9) ? 1 : 0);
        end
        chk("dec_wc_units", wc_b, 10);
        chk("dec_wc_tens", wc_c, 1);
        chk("dec_wp_tens", wp_c, 1);
        en_b = 1'b0;

        // 4: load and priority
        ld_a = 1'b1; lv_a = 4'd3;
        step();
        chk("ld3_q", q_a, 3);
        lv_a = 4'd12; en_a = 1'b1;
        step();
        chk("ld12_q", q_a, 12);
        chk("ld12_wc", wc_a, 1);
        chk("ld12_sf", sf_a, 0);
        ld_a = 1'b0; en_a = 1'b0;

        ld_b = 1'b1; lv_b = 4'd14;
        step();
        chk("ld_clamp_q", q_b, 9);
        chk("ld_clamp_tens", q_c, 0);
        ld_b = 1'b0;
        #1;
        chk("tc_en0_at_max", tc_b, 0);
        en_b = 1'b1;
        #1;
        chk("tc_zero_lat", tc_b, 1);
        clr_b = 1'b1; ld_b = 1'b1; lv_b = 4'd5;
        step();
        chk("clr_over_ld_q", q_b, 0);
        chk("clr_wp", wp_b, 0);
        chk("clr_wc", wc_b, 0);
        chk("clr_tens", q_c, 0);
        clr_b = 1'b0; ld_b = 1'b0; en_b = 1'b0;

        // 5: saturate mode
        ld_d = 1'b1; lv_d = 4'd13;
        step();
        chk("sat_ld13", q_d, 13);
        ld_d = 1'b0; en_d = 1'b1;
        step();
        chk("sat_q14", q_d, 14);
        chk("sat_sf14", sf_d, 0);
        step();
        chk("sat_q15a", q_d, 15);
        chk("sat_sf15a", sf_d, 0);
        chk("sat_tc", tc_d, 1);
        step();
        chk("sat_q15b", q_d, 15);
        chk("sat_sf15b", sf_d, 1);
        step();
        chk("sat_q15c", q_d, 15);
        chk("sat_sf15c", sf_d, 1);
        chk("sat_wc", wc_d, 0);
        chk("sat_wp", wp_d, 0);
        en_d = 1'b0; clr_d = 1'b1;
        step();
        chk("sat_clr_q", q_d, 0);
        chk("sat_clr_sf", sf_d, 0);
        clr_d = 1'b0; ld_d = 1'b1; lv_d = 4'd15;
        step();
        chk("sat_ld15_sf", sf_d, 1);
        ld_d = 1'b0;
        step();
        chk("sat_hold_q", q_d, 15);
        chk("sat_hold_sf", sf_d, 1);
        chk("sat_hold_tc", tc_d, 0);

        // 6: enable gating, then reset mid-count
        clr_a = 1'b1;
        step();
        chk("g_clr_q", q_a, 0);
        chk("g_clr_wc", wc_a, 0);
        clr_a = 1'b0;
        for (int k = 0; k < 14; k++) begin
            en_a = k[0];
            step();
            chk("gate_q", q_a, (k + 1) / 2);
        end
        en_a = 1'b1; reset = 1'b1;
        step();
        chk("mid_rst_q", q_a, 0);
        chk("mid_rst_wp", wp_a, 0);
        reset = 1'b0;

        // Reset at MAX with en squashes the wrap that would otherwise happen
        en_a = 1'b0; ld_a = 1'b1; lv_a = 4'd15;
        step();
        chk("pre_wrap_q", q_a, 15);
        ld_a = 1'b0; en_a = 1'b1; reset = 1'b1;
        step();
        chk("squash_q", q_a, 0);
        chk("squash_wp", wp_a, 0);
        chk("squash_wc", wc_a, 0);
        reset = 1'b0;

        // wrap_cnt rollover 255 -> 0
        repeat (16 * 255) step();
        chk("wc_255", wc_a, 255);
        repeat (16) step();
        chk("wc_roll", wc_a, 0);
        chk("wc_roll_q", q_a, 0);
        chk("wc_roll_wp", wp_a, 1);
        en_a = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
